lobster_fetch: RTL
==================

Name: lobster_fetch

Overview:
- Instruction fetch stage directly upstream of lobster_execman.
- Issues 64-bit-aligned bundle reads to the instruction memory port and buffers returned bundles in a small prefetch queue.
- Presents bundles, tagged with their PC, through a valid/ready interface that feeds the executor's data_in/addr_in.
- On a redirect (branch, trap, reset vector) it flushes the queue and discards stale in-flight responses.

Parameters:
- ADDR_WIDTH, 36, byte-address width; matches lobster_execman.
- QUEUE_DEPTH, 4, prefetch queue entries; power of two, at least 2.
- RESET_PC, 36'hF800, fetch address after reset; matches the execman reset PC.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_WIDTH  new fetch address; bits [2:0] ignored
- mem_req  out  1  read request valid
- mem_addr  out  ADDR_WIDTH  request address; bits [2:0] always 0
- mem_gnt  in  1  request accepted this cycle (handshake is mem_req && mem_gnt)
- mem_rvalid  in  1  read data valid; responses return in order, at most one per cycle
- mem_rdata  in  64  returned bundle
- bundle_valid  out  1  queue head valid
- bundle  out  64  queue head data
- bundle_pc  out  ADDR_WIDTH  address of queue head
- bundle_ready  in  1  consumer accepts the head this cycle

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high.

Reset:
- fetch_pc = RESET_PC; queue empty; outstanding = 0; discard = 0; state = RUN.
- Outputs: mem_req = 0, bundle_valid = 0, bundle = 0, bundle_pc = 0.
- Reset mid-operation drops everything. The memory port is reset by the same rst, so no pre-reset response may arrive afterwards.

Request issue:
- mem_req = (state == RUN) && (occupancy + outstanding < QUEUE_DEPTH), and the request is not issued in a cycle where redirect is high.
- mem_addr = fetch_pc, with low 3 bits zero.
- On handshake: fetch_pc += 8 (wraps modulo 2^ADDR_WIDTH) and outstanding += 1.
- mem_addr stays stable while mem_req && !mem_gnt.

Response:
- mem_rvalid with discard == 0: push {mem_rdata, tag pc}, outstanding -= 1.
- The tag pc comes from an internal response-PC counter that advances by 8 per accepted response.
- Credit accounting guarantees no overflow. A push while the queue is full is an assertion failure.

Output:
- Head is registered, with no combinational bypass. A response at cycle N gives bundle_valid at N+1, and that pop is the earliest possible.
- Pop on bundle_valid && bundle_ready.
- Simultaneous push and pop when full or empty is legal; occupancy is unchanged (full) or the head updates next cycle (empty).
- bundle and bundle_pc hold while bundle_valid && !bundle_ready.

FSM:
- RUN: normal operation.
  - On redirect: queue cleared, fetch_pc and response-PC set to {redirect_pc[ADDR_WIDTH-1:3], 3'b0}.
  - discard = outstanding minus any response arriving this cycle.
  - Go to DRAIN if that value is > 0, else stay in RUN.
- DRAIN: mem_req = 0. Each mem_rvalid decrements discard and outstanding, with data dropped. When discard reaches 0, go to RUN.
  - Another redirect in DRAIN only reloads fetch_pc and response-PC; the discard count continues.

Simultaneous events and priority:
- rst beats redirect, which beats push/pop.
- A response arriving in the redirect cycle is discarded.
- A pop in the redirect cycle is still consumed by the downstream stage; the flush clears everything else.

Counters:
- occupancy and outstanding are log2(QUEUE_DEPTH)+1 bits.
- discard ≤ QUEUE_DEPTH.

Decomposition:
- Package lobster_fetch_pkg holds:
  - the state enum {RUN, DRAIN};
  - the typedef of a queue entry (64-bit data plus ADDR_WIDTH pc);
  - the BUNDLE_BYTES = 8 constant.
- Sub-module lobster_fetch_fifo is a synchronous FIFO:
  - parameters DEPTH and WIDTH;
  - ports push, pop, flush, full, empty and count;
  - registered head.
- The fetch control, credit counters and FSM remain in lobster_fetch.

Test Plan:
- Reset, mem_gnt=1, memory with 2-cycle latency, bundle_ready=1 → first mem_addr = 0xF800, then 0xF808, 0xF810…; bundle_pc sequence 0xF800, 0xF808… with matching data; no gaps after steady state.
- bundle_ready=0 held, immediate grants → exactly 4 requests issued (0xF800–0xF818), mem_req drops; after ready=1 for one pop, exactly one new request at 0xF820.
- Two requests outstanding, redirect with redirect_pc=0x1003 → queue empty next cycle, both late responses dropped, next mem_addr = 0x1000, first bundle_pc = 0x1000.
- mem_gnt=0 for 5 cycles → mem_req=1 and mem_addr=0xF800 stable throughout, outstanding unchanged.
- Redirect in the same cycle as a mem_rvalid, and a second redirect during DRAIN to 0x2000 → neither stale bundle appears; fetch resumes at 0x2000.
- Reset asserted with a full queue and pending requests → the next cycle has bundle_valid=0, mem_req=0, and fetch restarts at 0xF800.

Source files
------------

// File: rtl/lobster_fetch_pkg.sv
// lobster_fetch_pkg
//   Shared types and constants for the lobster instruction fetch stage.
//   - fetch_state_e : fetch controller state (RUN / DRAIN)
//   - fetch_entry_t : one prefetch queue entry (64-bit bundle plus its PC)
//   - BUNDLE_BYTES  : size of one fetch bundle in bytes (fetch PC step)
package lobster_fetch_pkg;

  localparam int unsigned FETCH_ADDR_WIDTH = 36;
  localparam int unsigned BUNDLE_BITS      = 64;
  localparam int unsigned BUNDLE_BYTES     = 8;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [BUNDLE_BITS-1:0]      data;
    logic [FETCH_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/lobster_fetch_if.sv
// lobster_fetch_if
//   Bus bundle of the fetch stage: the instruction memory request/response
//   port and the bundle valid/ready output towards the executor.
//   - master : the fetch stage (drives mem_req/mem_addr and the bundle side)
//   - slave  : the environment (memory grants/returns data, consumer accepts)
interface lobster_fetch_if
  import lobster_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH
);

  logic                   mem_req;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_gnt;
  logic                   mem_rvalid;
  logic [BUNDLE_BITS-1:0] mem_rdata;

  logic                   bundle_valid;
  logic [BUNDLE_BITS-1:0] bundle;
  logic [ADDR_WIDTH-1:0]  bundle_pc;
  logic                   bundle_ready;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output bundle_valid, bundle, bundle_pc,
    input  bundle_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  bundle_valid, bundle, bundle_pc,
    output bundle_ready
  );

endinterface

// File: rtl/lobster_fetch_fifo.sv
// lobster_fetch_fifo
//   Synchronous FIFO with a registered head: dout is read straight out of the
//   storage flops, so a push becomes visible one cycle later.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     push, din       : write an entry (ignored when flush is high)
//     pop             : drop the head (ignored when empty)
//     flush           : discard all entries; wins over push and pop
//     dout            : current head entry
//     full, empty     : occupancy flags
//     count           : number of stored entries (0..DEPTH)
module lobster_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PW+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full queue is only accepted together with a pop, in which
  // case it lands in the slot the head is leaving.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Upstream credit accounting must never overrun the queue.
  assert property (@(posedge clk) disable iff (rst) !(push && !flush && full && !pop));

endmodule

// File: rtl/lobster_fetch.sv
// lobster_fetch
//   Instruction fetch stage feeding lobster_execman. Issues aligned 64-bit
//   bundle reads, buffers returned bundles with their PC in a prefetch queue,
//   and flushes/discards stale responses on redirect.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     redirect     : flush and restart fetch at redirect_pc
//     redirect_pc  : new fetch address (low 3 bits ignored)
//     bus          : memory request/response port and bundle valid/ready
//                    output (lobster_fetch_if master side)
//   ADDR_WIDTH must match the package entry width (FETCH_ADDR_WIDTH).
module lobster_fetch
  import lobster_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = FETCH_ADDR_WIDTH,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 36'hF800
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  lobster_fetch_if.master       bus
);

  localparam int                    CW          = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW:0]           DEPTH_LIMIT = (CW+1)'(QUEUE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(BUNDLE_BYTES);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         discard_q, discard_d;

  logic [CW-1:0]         occupancy;
  logic                  queue_empty;
  logic                  queue_full_unused;
  logic                  unused_redirect_lsbs;
  fetch_entry_t          push_entry;
  fetch_entry_t          head_entry;
  logic                  mem_req_int;
  logic                  handshake;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] redirect_target;

  assign redirect_target      = {redirect_pc[ADDR_WIDTH-1:3], 3'b000};
  assign unused_redirect_lsbs = ^redirect_pc[2:0];

  // Requests hold a credit from issue until their bundle leaves the queue,
  // so queued plus in-flight bundles can never exceed the queue depth.
  assign mem_req_int = !rst && (state_q == RUN) && !redirect &&
                       (({1'b0, occupancy} + {1'b0, outstanding_q}) < DEPTH_LIMIT);
  assign handshake   = mem_req_int && bus.mem_gnt;

  // Responses are only kept while running; a response in a redirect cycle
  // belongs to the old stream and is dropped.
  assign push        = bus.mem_rvalid && (state_q == RUN) && !redirect;
  assign pop         = !queue_empty && bus.bundle_ready;
  assign push_entry  = '{data: bus.mem_rdata, pc: resp_pc_q};

  // Fetch PC, response-PC, credit counters and RUN/DRAIN control.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (handshake) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
    if (push) begin
      resp_pc_d = resp_pc_q + PC_STEP;
    end

    case ({handshake, bus.mem_rvalid})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    case (state_q)
      RUN: begin
        // No request issues in a redirect cycle, so outstanding_d already
        // excludes any response that is arriving right now.
        if (redirect) begin
          fetch_pc_d = redirect_target;
          resp_pc_d  = redirect_target;
          discard_d  = outstanding_d;
          state_d    = (outstanding_d != '0) ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        if (bus.mem_rvalid) begin
          discard_d = discard_q - 1'b1;
        end
        if (discard_d == '0) begin
          state_d = RUN;
        end
        // A further redirect only moves the restart point; stale responses
        // still in flight are counted out as before.
        if (redirect) begin
          fetch_pc_d = redirect_target;
          resp_pc_d  = redirect_target;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Control registers; reset drops all in-flight bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  lobster_fetch_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .flush (redirect),
    .dout  (head_entry),
    .full  (queue_full_unused),
    .empty (queue_empty),
    .count (occupancy)
  );

  assign bus.mem_req      = mem_req_int;
  assign bus.mem_addr     = fetch_pc_q;
  assign bus.bundle_valid = !queue_empty;
  assign bus.bundle       = head_entry.data;
  assign bus.bundle_pc    = head_entry.pc;

endmodule
